// File: rtl/ws2812_ctrl.sv
// ws2812_ctrl: frame sequencer feeding the ws2812_out bit encoder.
// Reads LED_NUM pixel words from a synchronous buffer and shifts each one
// MSB-first into the encoder over the bit_rdy/bit_done handshake. After the
// last bit it holds the line idle for the latch period, then reports done.
module ws2812_ctrl #(
    parameter int          LED_NUM    = 64,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] CNT_LATCH  = 16'd10000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [23:0]           rd_data_in,
    output logic                  bit_rdy_out,
    output logic                  bit_data_out,
    input  logic                  bit_done_in,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_LATCH
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_PIX   = (ADDR_WIDTH + 1)'(LED_NUM - 1);
    localparam logic [ADDR_WIDTH:0] PIX_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [15:0]         LATCH_LAST = 16'(CNT_LATCH - 16'd1);

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] pix_cnt_q, pix_cnt_d;
    logic [4:0]          bit_idx_q, bit_idx_d;
    logic [23:0]         shreg_q, shreg_d;
    logic [15:0]         latch_cnt_q, latch_cnt_d;
    logic                bit_rdy_q, bit_rdy_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    // Next-state logic; outputs are derived from the next state so they come
    // straight out of flops and line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        latch_cnt_d = latch_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start_in) begin
                    pix_cnt_d = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d   = rd_data_in;
                bit_idx_d = 5'd0;
                state_d   = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (bit_done_in) begin
                    if (bit_idx_q != 5'd23) begin
                        shreg_d   = {shreg_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q + 5'd1;
                        state_d   = S_SEND;
                    end else if (pix_cnt_q != LAST_PIX) begin
                        pix_cnt_d = pix_cnt_q + PIX_ONE;
                        state_d   = S_READ;
                    end else begin
                        latch_cnt_d = 16'd0;
                        state_d     = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                latch_cnt_d = latch_cnt_q + 16'd1;
                if (latch_cnt_q == LATCH_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        bit_rdy_d    = (state_d == S_SEND);
        busy_d       = (state_d != S_IDLE);
        // Done is high during the final latch cycle (count at its last value).
        frame_done_d = (state_d == S_LATCH) && (latch_cnt_d == LATCH_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            pix_cnt_q    <= '0;
            bit_idx_q    <= 5'd0;
            shreg_q      <= 24'd0;
            latch_cnt_q  <= 16'd0;
            bit_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            latch_cnt_q  <= latch_cnt_d;
            bit_rdy_q    <= bit_rdy_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_addr_out    = pix_cnt_q[ADDR_WIDTH-1:0];
    assign bit_data_out   = shreg_q[23];
    assign bit_rdy_out    = bit_rdy_q;
    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;

endmodule
